// File: rtl/fpnew_f2i_arbiter.sv
// rtl/fpnew_f2i_arbiter.sv - shares one in-order float-to-int cast unit among NumReq requesters
//
// Purpose: round-robin (or fixed-priority) input arbitration onto a single cast
// unit, an in-flight ID FIFO that steers each in-order result back to the
// requester that issued it, and flush forwarding.
//
// Configuration macro: FPNEW_F2I_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest eligible index wins, no rr pointer
//   undefined -> round-robin starting at rr_ptr_q
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o [NumReq]   per-requester issue handshake
//   req_operand_i, req_rnd_mode_i,
//   req_op_mod_i, req_int_fmt_i        per-requester operation fields
//   unit_valid_o/unit_ready_i          cast unit input handshake
//   unit_operand_o, unit_rnd_mode_o,
//   unit_op_mod_o, unit_int_fmt_o      granted operation fields
//   unit_valid_i/unit_ready_o          cast unit output handshake
//   unit_result_i, unit_status_i       cast unit result and status flags
//   rsp_valid_o/rsp_ready_i [NumReq]   per-requester response handshake
//   rsp_result_o, rsp_status_o         shared response bus
//   flush_i, unit_flush_o              flush in, combinational copy to unit
//   busy_o                             operations in flight
//
// Rounding mode is 3 bits, integer format 2 bits, status 5 bits {NV,DZ,OF,UF,NX}.

module fpnew_f2i_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned SrcWidth    = 32,
    parameter int unsigned DstWidth    = 64,
    parameter int unsigned MaxInflight = 4,
    localparam int unsigned IdWidth    = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned CntWidth   = $clog2(MaxInflight + 1),
    localparam int unsigned PtrWidth   = (MaxInflight > 1) ? $clog2(MaxInflight) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    input  logic [NumReq-1:0][SrcWidth-1:0]    req_operand_i,
    input  logic [NumReq-1:0][2:0]             req_rnd_mode_i,
    input  logic [NumReq-1:0]                  req_op_mod_i,
    input  logic [NumReq-1:0][1:0]             req_int_fmt_i,
    output logic                               unit_valid_o,
    input  logic                               unit_ready_i,
    output logic [SrcWidth-1:0]                unit_operand_o,
    output logic [2:0]                         unit_rnd_mode_o,
    output logic                               unit_op_mod_o,
    output logic [1:0]                         unit_int_fmt_o,
    input  logic                               unit_valid_i,
    output logic                               unit_ready_o,
    input  logic [DstWidth-1:0]                unit_result_i,
    input  logic [4:0]                         unit_status_i,
    output logic [NumReq-1:0]                  rsp_valid_o,
    input  logic [NumReq-1:0]                  rsp_ready_i,
    output logic [DstWidth-1:0]                rsp_result_o,
    output logic [4:0]                         rsp_status_o,
    input  logic                               flush_i,
    output logic                               unit_flush_o,
    output logic                               busy_o
);

    logic [MaxInflight-1:0][IdWidth-1:0] fifo_q;
    logic [PtrWidth-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]                 cnt_q;
    logic [IdWidth-1:0]                  winner, head_id;
    logic                                any_valid, issue, pop, route_en;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxInflight - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FPNEW_F2I_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        // Descending scan: the last hit, i.e. the lowest index, wins.
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_valid_i[i]) winner = IdWidth'(i);
        end
    end
`else
    logic [IdWidth-1:0] rr_ptr_q;
    logic [IdWidth:0]   rr_sum;

    always_comb begin
        winner = '0;
        rr_sum = '0;
        // Descending offset scan: the last hit is the smallest offset from rr_ptr_q.
        for (int i = NumReq - 1; i >= 0; i--) begin
            rr_sum = {1'b0, rr_ptr_q} + (IdWidth + 1)'(i);
            if (rr_sum >= (IdWidth + 1)'(NumReq)) rr_sum = rr_sum - (IdWidth + 1)'(NumReq);
            if (req_valid_i[rr_sum[IdWidth-1:0]]) winner = rr_sum[IdWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (issue) begin
            rr_ptr_q <= (winner == IdWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
        end
    end
`endif

    assign any_valid = |req_valid_i;

    // A push is refused at full even if a pop happens the same cycle, so the
    // response-side ready never feeds the issue side combinationally.
    assign unit_valid_o = rst_ni & any_valid & (cnt_q < CntWidth'(MaxInflight)) & ~flush_i;
    assign issue        = unit_valid_o & unit_ready_i;
    assign req_ready_o  = issue ? (NumReq'(1) << winner) : '0;

    assign unit_operand_o  = req_operand_i[winner];
    assign unit_rnd_mode_o = req_rnd_mode_i[winner];
    assign unit_op_mod_o   = req_op_mod_i[winner];
    assign unit_int_fmt_o  = req_int_fmt_i[winner];

    // Results are routed only while an ID is pending; a stray unit_valid_i
    // with an empty FIFO sees no ready and is therefore held by the unit.
    assign head_id      = fifo_q[rd_ptr_q];
    assign route_en     = rst_ni & (cnt_q != '0) & ~flush_i;
    assign unit_ready_o = route_en & rsp_ready_i[head_id];
    assign rsp_valid_o  = (route_en & unit_valid_i) ? (NumReq'(1) << head_id) : '0;
    assign pop          = unit_valid_i & unit_ready_o;
    assign rsp_result_o = unit_result_i;
    assign rsp_status_o = unit_status_i;

    assign unit_flush_o = flush_i;
    assign busy_o       = (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (issue) begin
                fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CntWidth'(issue) - CntWidth'(pop);
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(issue && cnt_q == CntWidth'(MaxInflight)));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && cnt_q == '0));

endmodule

// File: tb/tb_fpnew_f2i_arbiter.sv
// tb/tb_fpnew_f2i_arbiter.sv - directed self-checking bench for fpnew_f2i_arbiter

module tb_fpnew_f2i_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_valid, req_ready;
    logic [3:0][31:0]  req_operand;
    logic [3:0][2:0]   req_rnd_mode;
    logic [3:0]        req_op_mod;
    logic [3:0][1:0]   req_int_fmt;
    logic              unit_valid_o, unit_ready_i;
    logic [31:0]       unit_operand;
    logic [2:0]        unit_rnd_mode;
    logic              unit_op_mod;
    logic [1:0]        unit_int_fmt;
    logic              unit_valid_i, unit_ready_o;
    logic [63:0]       unit_result;
    logic [4:0]        unit_status;
    logic [3:0]        rsp_valid, rsp_ready;
    logic [63:0]       rsp_result;
    logic [4:0]        rsp_status;
    logic              flush, unit_flush, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fpnew_f2i_arbiter #(.NumReq(4), .SrcWidth(32), .DstWidth(64), .MaxInflight(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operand_i(req_operand), .req_rnd_mode_i(req_rnd_mode),
        .req_op_mod_i(req_op_mod), .req_int_fmt_i(req_int_fmt),
        .unit_valid_o(unit_valid_o), .unit_ready_i(unit_ready_i),
        .unit_operand_o(unit_operand), .unit_rnd_mode_o(unit_rnd_mode),
        .unit_op_mod_o(unit_op_mod), .unit_int_fmt_o(unit_int_fmt),
        .unit_valid_i(unit_valid_i), .unit_ready_o(unit_ready_o),
        .unit_result_i(unit_result), .unit_status_i(unit_status),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
        .flush_i(flush), .unit_flush_o(unit_flush), .busy_o(busy)
    );

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        req_valid = 4'hF; unit_ready_i = 1'b1; unit_valid_i = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
        n_cmp++; if (unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_unit_valid got %b want 0", unit_valid_o); end
        n_cmp++; if (unit_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_unit_ready got %b want 0", unit_ready_o); end
        n_cmp++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_valid got %h want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (unit_flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush_copy got %b want 1", unit_flush); end
        flush = 1'b0;
        #1;
        n_cmp++; if (unit_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush_copy0 got %b want 0", unit_flush); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 4'h0; unit_valid_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid    = 4'hF;
            unit_valid_i = (k > 0);
            unit_result  = 64'(k) + 64'h1000;
            #1;
            exp = 4'b0001 << (k % 4);
            n_cmp++; if (req_ready !== exp) begin n_fail++; $display("FAIL rr_grant k=%0d got %h want %h", k, req_ready, exp); end
            n_cmp++; if (unit_operand !== 32'h100 + 32'(k % 4)) begin n_fail++; $display("FAIL rr_operand k=%0d got %h want %h", k, unit_operand, 32'h100 + 32'(k % 4)); end
            n_cmp++; if (unit_rnd_mode !== 3'(k % 4)) begin n_fail++; $display("FAIL rr_rnd_mode k=%0d got %0d want %0d", k, unit_rnd_mode, k % 4); end
            if (k > 0) begin
                exp = 4'b0001 << ((k - 1) % 4);
                n_cmp++; if (rsp_valid !== exp) begin n_fail++; $display("FAIL rr_rsp_id k=%0d got %h want %h", k, rsp_valid, exp); end
                n_cmp++; if (rsp_result !== 64'(k) + 64'h1000) begin n_fail++; $display("FAIL rr_rsp_result k=%0d got %h want %h", k, rsp_result, 64'(k) + 64'h1000); end
            end
        end
        @(negedge clk);
        req_valid = 4'h0; unit_valid_i = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL rr_last_rsp got %h want 8", rsp_valid); end
        n_cmp++; if (unit_ready_o !== 1'b1) begin n_fail++; $display("FAIL rr_last_ready got %b want 1", unit_ready_o); end
        @(negedge clk);
        unit_valid_i = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_credit_limit();
        logic [3:0] exp;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = 4'b0101; unit_valid_i = 1'b0;
            #1;
            exp = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            n_cmp++; if (req_ready !== exp) begin n_fail++; $display("FAIL credit_grant k=%0d got %h want %h", k, req_ready, exp); end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL credit_full_valid got %b want 0", unit_valid_o); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL credit_full_busy got %b want 1", busy); end
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL credit_full_ready got %h want 0", req_ready); end
        @(negedge clk);
        unit_valid_i = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL credit_pop_id got %h want 1", rsp_valid); end
        n_cmp++; if (unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL credit_pop_nopush got %b want 0", unit_valid_o); end
        @(negedge clk);
        unit_valid_i = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL credit_refill got %h want 1", req_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL credit_refull got %b want 0", unit_valid_o); end
        req_valid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            unit_valid_i = 1'b1;
            #1;
            exp = (k % 2 == 0) ? 4'b0100 : 4'b0001;
            n_cmp++; if (rsp_valid !== exp) begin n_fail++; $display("FAIL credit_drain k=%0d got %h want %h", k, rsp_valid, exp); end
        end
        @(negedge clk);
        unit_valid_i = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL credit_drained_busy got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 4'b0010; unit_valid_i = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant got %h want 2", req_ready); end
        @(negedge clk);
        req_valid = 4'h0; unit_valid_i = 1'b1;
        unit_result = 64'h0000_0000_0000_002A; unit_status = 5'b00001;
        rsp_ready = 4'b1101;
        #1;
        n_cmp++; if (unit_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got %b want 0", unit_ready_o); end
        @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_no_pop got %b want 1", busy); end
        rsp_ready = 4'hF;
        #1;
        n_cmp++; if (unit_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", unit_ready_o); end
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_rsp_id got %h want 2", rsp_valid); end
        n_cmp++; if (rsp_result !== 64'h2A) begin n_fail++; $display("FAIL bp_result got %h want 2a", rsp_result); end
        n_cmp++; if (rsp_status !== 5'b00001) begin n_fail++; $display("FAIL bp_status got %b want 00001", rsp_status); end
        @(negedge clk);
        unit_valid_i = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_done_busy got %b want 0", busy); end
    endtask

    task automatic test_flush();
        logic [3:0] exp;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'hF; unit_valid_i = 1'b0;
            #1;
            exp = (k == 0) ? 4'b0100 : (k == 1) ? 4'b1000 : 4'b0001;
            n_cmp++; if (req_ready !== exp) begin n_fail++; $display("FAIL flush_fill k=%0d got %h want %h", k, req_ready, exp); end
        end
        @(negedge clk);
        req_valid = 4'b1000; flush = 1'b1; unit_valid_i = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL flush_no_grant got %h want 0", req_ready); end
        n_cmp++; if (unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_unit_valid got %b want 0", unit_valid_o); end
        n_cmp++; if (unit_flush !== 1'b1) begin n_fail++; $display("FAIL flush_copy got %b want 1", unit_flush); end
        n_cmp++; if (unit_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_unit_ready got %b want 0", unit_ready_o); end
        n_cmp++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL flush_rsp_valid got %h want 0", rsp_valid); end
        @(negedge clk);
        flush = 1'b0; req_valid = 4'h0; unit_valid_i = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL flush_rr_kept got %h want 2", req_ready); end
        @(negedge clk);
        req_valid = 4'h0; unit_valid_i = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL flush_after_rsp got %h want 2", rsp_valid); end
        @(negedge clk);
        unit_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_g0 got %h want 1", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rstmid_g1 got %h want 2", req_ready); end
        @(negedge clk);
        req_valid = 4'hF; unit_valid_i = 1'b1; rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rstmid_req_ready got %h want 0", req_ready); end
        n_cmp++; if (unit_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_unit_valid got %b want 0", unit_valid_o); end
        n_cmp++; if (unit_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_unit_ready got %b want 0", unit_ready_o); end
        n_cmp++; if (rsp_valid !== 4'h0) begin n_fail++; $display("FAIL rstmid_rsp_valid got %h want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1; unit_valid_i = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant got %h want 1", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
    endtask

    task automatic test_fixed_prio();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req_valid = 4'b1010; unit_valid_i = (k > 0);
            #1;
            n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL fixed_grant k=%0d got %h want 2", k, req_ready); end
        end
        @(negedge clk);
        req_valid = 4'h0;
    endtask

    initial begin
        req_valid = 4'h0; unit_ready_i = 1'b1; unit_valid_i = 1'b0;
        rsp_ready = 4'hF; flush = 1'b0;
        unit_result = '0; unit_status = '0;
        for (int i = 0; i < 4; i++) begin
            req_operand[i]  = 32'h100 + 32'(i);
            req_rnd_mode[i] = 3'(i);
            req_op_mod[i]   = 1'(i);
            req_int_fmt[i]  = 2'(i);
        end
        test_reset();
`ifdef FPNEW_F2I_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
        test_credit_limit();
        test_backpressure();
        test_flush();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
